simon_seq_engine: RTL

//   Datapath responder to the Simon control FSM. Acts on the FSM's ld/show/comp/match strobes.

---
 rtl/simon_seq_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/simon_seq_engine.sv
// Simon game datapath: holds the LFSR-generated colour sequence, plays the current
// round on the LEDs and judges player presses for the control FSM.
module simon_seq_engine #(
    parameter int          MAX_LEN    = 16,
    parameter int          STEP_TICKS = 25000000,
    parameter int          GAP_TICKS  = 12500000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         IW         = $clog2(MAX_LEN)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic        show,
    input  logic        comp,
    input  logic        match,
    input  logic [3:0]  btn,
    output logic [3:0]  led,
    output logic        cor,
    output logic        finish,
    output logic        show_done,
    output logic        press_vld,
    output logic [IW:0] round_len
);

    localparam int TMAX = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
    localparam logic [IW:0] LEN_MAX = (IW+1)'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, FILL, PLAY_ON, PLAY_GAP, CAPTURE} state_t;

    state_t        state;
    logic [1:0]    mem [MAX_LEN];
    logic [15:0]   lfsr;
    logic [TW-1:0] tick;
    logic [IW-1:0] idx, play_ptr, fp;
    logic          regen, armed;
    logic          ld_prev, show_prev;
    logic [3:0]    btn_prev;

    logic          ld_rise, show_rise, press_edge, lfsr_fb;
    logic [IW-1:0] last_idx, play_nxt;
    logic [IW-1:0] idx_m;
    logic [IW:0]   rlen_m;
    logic          fin_m, regen_m, armed_m;
    logic          cor_n, fin_n;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    assign ld_rise    = ld & ~ld_prev;
    assign show_rise  = show & ~show_prev;
    assign press_edge = (btn_prev == 4'b0) && (btn != 4'b0);
    assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign last_idx   = IW'(round_len - (IW+1)'(1));
    assign play_nxt   = play_ptr + IW'(1);

    // Match is applied before any press in the same cycle, so the press is
    // judged against the advanced index and re-armed state.
    always_comb begin
        idx_m   = idx;
        rlen_m  = round_len;
        fin_m   = finish;
        regen_m = regen;
        armed_m = armed;
        if (match) begin
            armed_m = 1'b1;
            fin_m   = 1'b0;
            if (finish) begin
                idx_m = '0;
                if (round_len == LEN_MAX) regen_m = 1'b1;
                else                      rlen_m  = round_len + (IW+1)'(1);
            end else if (idx != last_idx) begin
                idx_m = idx + IW'(1);
            end
        end
        cor_n = (btn == onehot(mem[idx_m]));
        fin_n = cor_n && (idx_m == IW'(rlen_m - (IW+1)'(1)));
    end

    // Sequence store has no reset; its contents are only meaningful after a fill.
    always_ff @(posedge clk) begin
        if (state == FILL && ld) mem[fp] <= lfsr[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lfsr      <= LFSR_SEED;
            tick      <= '0;
            idx       <= '0;
            play_ptr  <= '0;
            fp        <= '0;
            regen     <= 1'b1;
            armed     <= 1'b1;
            ld_prev   <= 1'b0;
            show_prev <= 1'b0;
            btn_prev  <= 4'b0;
            led       <= 4'b0;
            cor       <= 1'b0;
            finish    <= 1'b0;
            show_done <= 1'b0;
            press_vld <= 1'b0;
            round_len <= (IW+1)'(1);
        end else begin
            lfsr      <= {lfsr[14:0], lfsr_fb};
            ld_prev   <= ld;
            show_prev <= show;
            btn_prev  <= btn;
            show_done <= 1'b0;
            press_vld <= 1'b0;
            idx       <= idx_m;
            round_len <= rlen_m;
            finish    <= fin_m;
            regen     <= regen_m;
            armed     <= armed_m;
            if (match) cor <= 1'b0;

            if (ld_rise) begin
                idx   <= '0;
                armed <= 1'b1;
                led   <= 4'b0;
                if (regen_m) begin
                    state     <= FILL;
                    fp        <= '0;
                    round_len <= (IW+1)'(1);
                    regen     <= 1'b0;
                end else begin
                    state <= IDLE;
                end
            end else if (state == FILL) begin
                if (ld) fp    <= fp + IW'(1);
                else    state <= IDLE;
            end else if (ld) begin
                state <= IDLE;
                led   <= 4'b0;
            end else if (show_rise) begin
                play_ptr <= '0;
                tick     <= '0;
                cor      <= 1'b0;
                finish   <= 1'b0;
                led      <= onehot(mem[0]);
                state    <= PLAY_ON;
            end else begin
                case (state)
                    PLAY_ON: begin
                        if (tick == TW'(STEP_TICKS - 1)) begin
                            tick  <= '0;
                            led   <= 4'b0;
                            state <= PLAY_GAP;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    PLAY_GAP: begin
                        if (tick == TW'(GAP_TICKS - 1)) begin
                            tick <= '0;
                            if (play_ptr == last_idx) begin
                                show_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                play_ptr <= play_nxt;
                                led      <= onehot(mem[play_nxt]);
                                state    <= PLAY_ON;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    default: begin
                        if (comp) begin
                            state <= CAPTURE;
                            led   <= btn;
                            if (press_edge && armed_m) begin
                                cor       <= cor_n;
                                finish    <= fin_n;
                                press_vld <= 1'b1;
                                armed     <= 1'b0;
                                if (!cor_n) regen <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            led   <= 4'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
